instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, sets the PC loaded on reset.
REQ-002 Parameter NOP, default 32'h0000_0013, sets the value driven on instr when no instruction is held.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts the request.
REQ-007 imem_addr  output  32  fetch address, equal to the current PC.
REQ-008 imem_resp_valid  input  1  response data valid.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 instr_valid  output  1  instruction presented to decode.
REQ-011 instr_ready  input  1  decode consumes the instruction.
REQ-012 instr  output  32  instruction word to decode.
REQ-013 instr_pc  output  32  address of instr.
REQ-014 redirect_valid  input  1  branch/jump redirect request.
REQ-015 redirect_pc  input  32  redirect target.
REQ-016 fetch_count  output  32  count of instructions handed to decode.

Function
REQ-017 The block SHALL implement an FSM with states REQ, WAIT and HOLD, plus a kill flag; at most one memory request is outstanding.
REQ-018 In REQ: imem_req_valid=1 and imem_addr=pc; imem_req_valid&imem_req_ready moves the FSM to WAIT next cycle; otherwise it stays in REQ.
REQ-019 In WAIT with imem_resp_valid=1 and kill=0: instr<=imem_resp_data, instr_pc<=pc, pc<=pc+4, go to HOLD.
REQ-020 In WAIT with imem_resp_valid=1 and kill=1: discard the data, clear kill, go to REQ; pc is unchanged.
REQ-021 In HOLD: instr_valid=1; instr_ready=1 increments fetch_count and moves the FSM to REQ next cycle.
REQ-022 instr_valid SHALL be 1 only in HOLD. Outside HOLD, instr=NOP; instr_pc retains its last value.
REQ-023 Latency: request accepted at cycle N, response at cycle M>N, instr_valid=1 from cycle M+1. Peak throughput is one instruction per 3 cycles.
REQ-024 instr and instr_pc SHALL be stable while in HOLD.
REQ-025 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4=32'h0000_0000. fetch_count SHALL also wrap at 2^32.
REQ-026 Redirect SHALL load pc<=redirect_pc with bits [1:0] forced to 0. Redirect has priority over the sequential pc+4 update.
REQ-027 Redirect in REQ with no request handshake: stay in REQ. imem_addr changes to the new pc next cycle; an unaccepted address may change.
REQ-028 Redirect in REQ with a request handshake in the same cycle: go to WAIT with kill=1.
REQ-029 Redirect in WAIT with no response: kill<=1, stay in WAIT.
REQ-030 Redirect in WAIT with a response in the same cycle: discard the response, go to REQ, kill=0.
REQ-031 Redirect in HOLD: drop the held instruction and go to REQ. If instr_ready=1 in the same cycle, the handshake completes and fetch_count increments; otherwise it does not.
REQ-032 imem_resp_valid in REQ or HOLD SHALL be ignored.
REQ-033 imem_req_valid SHALL be 0 in WAIT and HOLD.

Reset
REQ-034 With reset_n=0 the block SHALL immediately force: state=REQ, pc=RESET_PC, kill=0, fetch_count=0, instr=NOP, instr_pc=RESET_PC, instr_valid=0, imem_req_valid=0.
REQ-035 In the first cycle after reset_n rises, imem_req_valid=1 and imem_addr=RESET_PC.
REQ-036 Reset mid-operation SHALL abandon any outstanding request. The memory shares reset_n, so no stale response arrives after reset.

Verification
REQ-037 Reset, then ready=1 and a 1-cycle response 32'h0020_8093 -> instr_valid=1 with instr=32'h0020_8093, instr_pc=0; after instr_ready, next imem_addr=4 and fetch_count=1.
REQ-038 instr_ready held 0 for 5 cycles in HOLD -> instr and instr_pc stable, no new request; release -> fetch_count increments once.
REQ-039 Redirect to 32'h0000_0103 during WAIT, response arrives 2 cycles later -> response discarded, next imem_addr=32'h0000_0100, instr_valid stays 0 until the new fetch returns.
REQ-040 Redirect with a same-cycle response in WAIT, then redirect in HOLD with instr_ready=0 -> no instruction delivered, fetch_count unchanged.
REQ-041 redirect_pc=32'hFFFF_FFFC, fetch completes -> instr_pc=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-042 reset_n pulsed low during WAIT -> outputs take reset values asynchronously; after release, imem_addr=RESET_PC and fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit.
// Issues one memory request at a time, holds the returned word for decode,
// and handles branch/jump redirects at any point in the fetch cycle.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // Request is gated by reset_n so it drops the instant reset asserts.
    assign imem_req_valid = reset_n && (state_q == ST_REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == ST_HOLD);
    assign instr          = (state_q == ST_HOLD) ? instr_q : NOP;
    assign instr_pc       = instr_pc_q;
    assign fetch_count    = count_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            instr_q    <= NOP;
            instr_pc_q <= RESET_PC;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic; a redirect always wins over the sequential pc+4.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        count_d    = count_q;

        unique case (state_q)
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    kill_d  = redirect_valid;
                end
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    kill_d = 1'b0;
                    if (redirect_valid || kill_q) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_HOLD;
                        instr_d    = imem_resp_data;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    count_d = count_q + 32'd1;
                end
                if (instr_ready || redirect_valid) begin
                    state_d = ST_REQ;
                end
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_instruction_fetch;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_VAL = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    instruction_fetch #(
        .RESET_PC (RST_PC),
        .NOP      (NOP_VAL)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    // Reference model: what the fetcher is doing, as plain flags.
    logic        m_inflight;   // a request has been accepted, no reply yet
    logic        m_have;       // an instruction is being offered to decode
    logic        m_stale;      // the in-flight reply belongs to an old path
    logic [31:0] m_pc;
    logic [31:0] m_word;
    logic [31:0] m_wpc;
    logic [31:0] m_count;

    // Memory model used by the random phase.
    logic        mem_busy;
    int unsigned mem_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_inflight = 1'b0;
        m_have     = 1'b0;
        m_stale    = 1'b0;
        m_pc       = RST_PC;
        m_word     = NOP_VAL;
        m_wpc      = RST_PC;
        m_count    = '0;
        mem_busy   = 1'b0;
        mem_wait   = 0;
    endtask

    task automatic check_all();
        chk("req_valid",   {31'd0, imem_req_valid}, {31'd0, reset_n && !m_inflight && !m_have});
        chk("imem_addr",   imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
        chk("instr",       instr, m_have ? m_word : NOP_VAL);
        chk("instr_pc",    instr_pc, m_wpc);
        chk("fetch_count", fetch_count, m_count);
    endtask

    // Advance the model by one clock given the inputs held across that edge.
    task automatic model_step(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic ir, input logic rdv, input logic [31:0] rpc);
        logic [31:0] tgt;
        tgt = rpc & 32'hFFFF_FFFC;
        if (m_have) begin
            if (ir) m_count = m_count + 32'd1;
            if (ir || rdv) m_have = 1'b0;
        end else if (m_inflight) begin
            if (rv) begin
                m_inflight = 1'b0;
                if (!rdv && !m_stale) begin
                    m_have = 1'b1;
                    m_word = rd;
                    m_wpc  = m_pc;
                    m_pc   = m_pc + 32'd4;
                end
                m_stale = 1'b0;
            end else if (rdv) begin
                m_stale = 1'b1;
            end
        end else if (rdy) begin
            m_inflight = 1'b1;
            m_stale    = rdv;
        end
        if (rdv) m_pc = tgt;
    endtask

    // Drive one cycle of inputs (at a falling edge), then check at the next falling edge.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic ir, input logic rdv, input logic [31:0] rpc);
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = rd;
        instr_ready     = ir;
        redirect_valid  = rdv;
        redirect_pc     = rpc;
        model_step(rdy, rv, rd, ir, rdv, rpc);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic        rdy, rv, ir, rdv, hs;
        logic [31:0] rd, rpc;

        reset_n         = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_all();
        reset_n = 1'b1;
        #1;
        chk("post_reset_req", {31'd0, imem_req_valid}, 32'd1);
        chk("post_reset_addr", imem_addr, RST_PC);

        // Basic fetch with 1-cycle response
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 32'h0020_8093, 0, 0, '0);
        chk("basic_instr", instr, 32'h0020_8093);
        chk("basic_pc", instr_pc, 32'h0000_0000);
        chk("basic_valid", {31'd0, instr_valid}, 32'd1);

        // Decode stall for 5 cycles, with ignored responses and ready high
        for (int k = 0; k < 5; k++) step(1, k[0], 32'hDEAD_BEEF, 0, 0, '0);
        chk("stall_instr", instr, 32'h0020_8093);
        chk("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
        step(0, 0, '0, 1, 0, '0);
        chk("release_addr", imem_addr, 32'h0000_0004);
        chk("release_count", fetch_count, 32'd1);

        // Redirect while waiting, response two cycles later is discarded
        step(1, 0, '0, 0, 0, '0);
        step(0, 0, '0, 0, 1, 32'h0000_0103);
        step(0, 0, '0, 0, 0, '0);
        step(0, 1, 32'h1111_1111, 0, 0, '0);
        chk("kill_addr", imem_addr, 32'h0000_0100);
        chk("kill_valid", {31'd0, instr_valid}, 32'd0);
        step(1, 0, '0, 0, 0, '0);
        step(0, 0, '0, 0, 0, '0);
        step(0, 1, 32'h2222_2222, 0, 0, '0);
        chk("refetch_pc", instr_pc, 32'h0000_0100);
        step(0, 0, '0, 1, 0, '0);

        // Redirect with same-cycle response, then redirect in HOLD without ready
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 32'h3333_3333, 0, 1, 32'h0000_0200);
        chk("rr_valid", {31'd0, instr_valid}, 32'd0);
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 32'h4444_4444, 0, 0, '0);
        step(0, 0, '0, 0, 1, 32'h0000_0300);
        chk("hold_redir_count", fetch_count, 32'd2);
        chk("hold_redir_addr", imem_addr, 32'h0000_0300);

        // Address wrap at the top of the address space
        step(0, 0, '0, 0, 1, 32'hFFFF_FFFE);
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 32'h5555_5555, 0, 0, '0);
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        step(0, 0, '0, 1, 0, '0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Fetch once more, then reset in the middle of a wait
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 32'h6666_6666, 0, 0, '0);
        step(0, 0, '0, 1, 0, '0);
        step(1, 0, '0, 0, 0, '0);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        reset_n = 1'b1;
        #1;
        chk("rst2_addr", imem_addr, RST_PC);
        chk("rst2_req", {31'd0, imem_req_valid}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = $urandom;
            if (mem_busy && mem_wait == 0) rv = 1'b1;
            else rv = !mem_busy && ($urandom_range(0, 7) == 0);
            ir  = ($urandom_range(0, 2) != 0);
            rdv = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            hs  = !m_inflight && !m_have && rdy;
            if (mem_busy) begin
                if (rv) mem_busy = 1'b0;
                else mem_wait = mem_wait - 1;
            end
            if (hs) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(0, 2);
            end
            step(rdy, rv, rd, ir, rdv, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
